// File: rtl/paddle_controller.sv
// Paddle position controller: synchronizes and debounces buttons,
// derives a frame tick from VSYNC and moves the paddle with acceleration.
module paddle_controller #(
  parameter logic [9:0]  PADDLE_LENGTH_PIXEL = 10'd60,
  parameter logic [9:0]  MIN_X_PIXEL         = 10'd8,
  parameter logic [9:0]  MAX_X_PIXEL         = 10'd732,
  parameter logic [9:0]  RESET_X_PIXEL       = 10'd370,
  parameter logic [19:0] DEBOUNCE_CYCLES     = 20'd500000,
  parameter logic [3:0]  ACCEL_FRAMES        = 4'd4,
  parameter logic [3:0]  MAX_SPEED           = 4'd6
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       ENABLE,
  input  logic       VSYNC,
  output logic [9:0] PADDLE_X_PIXEL,
  output logic       FRAME_TICK,
  output logic       MOVING
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT
  } state_t;

  logic        r_l_s1, r_l_s2, r_r_s1, r_r_s2;
  logic        r_v_s1, r_v_s2, r_v_q, r_v_d;
  logic        r_l_acc, r_r_acc;
  logic [19:0] r_l_cnt, r_r_cnt;
  logic        r_tick;
  state_t      r_state, w_next;
  logic [3:0]  r_speed, w_speed;
  logic [3:0]  r_fcnt, w_fcnt;
  logic [9:0]  r_x, w_x;
  logic        r_moving;
  logic        w_req_l, w_req_r;
  logic [10:0] w_lo, w_hi;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_l_s1 <= 1'b0;
      r_l_s2 <= 1'b0;
      r_r_s1 <= 1'b0;
      r_r_s2 <= 1'b0;
      r_v_s1 <= 1'b0;
      r_v_s2 <= 1'b0;
      r_v_q  <= 1'b0;
      r_v_d  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_l_s1 <= BTN_LEFT;
      r_l_s2 <= r_l_s1;
      r_r_s1 <= BTN_RIGHT;
      r_r_s2 <= r_r_s1;
      r_v_s1 <= VSYNC;
      r_v_s2 <= r_v_s1;
      r_v_q  <= r_v_s2;
      r_v_d  <= r_v_q;
      r_tick <= r_v_q & ~r_v_d;
    end
  end

  // Accept a button change only after it has been stable long enough
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_l_acc <= 1'b0;
      r_r_acc <= 1'b0;
      r_l_cnt <= '0;
      r_r_cnt <= '0;
    end else begin
      if (r_l_s2 == r_l_acc) begin
        r_l_cnt <= '0;
      end else if (r_l_cnt == DEBOUNCE_CYCLES - 20'd1) begin
        r_l_acc <= r_l_s2;
        r_l_cnt <= '0;
      end else begin
        r_l_cnt <= r_l_cnt + 20'd1;
      end
      if (r_r_s2 == r_r_acc) begin
        r_r_cnt <= '0;
      end else if (r_r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
        r_r_acc <= r_r_s2;
        r_r_cnt <= '0;
      end else begin
        r_r_cnt <= r_r_cnt + 20'd1;
      end
    end
  end

  assign w_req_l = r_l_acc & ~r_r_acc;
  assign w_req_r = r_r_acc & ~r_l_acc;

  always_comb begin
    w_next  = r_state;
    w_speed = r_speed;
    w_fcnt  = r_fcnt;
    w_x     = r_x;
    w_lo    = '0;
    w_hi    = '0;
    if (r_tick) begin
      if (!ENABLE)
        w_next = S_IDLE;
      else if (w_req_l)
        w_next = S_LEFT;
      else if (w_req_r)
        w_next = S_RIGHT;
      else
        w_next = S_IDLE;

      if (w_next == S_IDLE) begin
        w_speed = 4'd0;
        w_fcnt  = 4'd0;
      end else if (w_next != r_state) begin
        w_speed = 4'd1;
        w_fcnt  = 4'd0;
      end else if (r_fcnt == ACCEL_FRAMES - 4'd1) begin
        w_fcnt = 4'd0;
        if (r_speed < MAX_SPEED)
          w_speed = r_speed + 4'd1;
      end else begin
        w_fcnt = r_fcnt + 4'd1;
      end

      // 11-bit math so a step past zero is caught instead of wrapping
      w_lo = {1'b0, r_x} - {7'd0, w_speed};
      w_hi = {1'b0, r_x} + {7'd0, w_speed};
      if (w_next == S_LEFT)
        w_x = (w_lo[10] || w_lo < {1'b0, MIN_X_PIXEL}) ?
              MIN_X_PIXEL : w_lo[9:0];
      else if (w_next == S_RIGHT)
        w_x = (w_hi > {1'b0, MAX_X_PIXEL}) ?
              MAX_X_PIXEL : w_hi[9:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_speed  <= 4'd0;
      r_fcnt   <= 4'd0;
      r_x      <= RESET_X_PIXEL;
      r_moving <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_speed  <= w_speed;
      r_fcnt   <= w_fcnt;
      r_x      <= w_x;
      r_moving <= (w_next != S_IDLE);
    end
  end

  assign PADDLE_X_PIXEL = r_x;
  assign FRAME_TICK     = r_tick;
  assign MOVING         = r_moving;

endmodule

// File: tb/tb_paddle_controller.sv
// Scoreboard bench for paddle_controller: frames push expected X/MOVING,
// a monitor compares one cycle after every FRAME_TICK.
module tb_paddle_controller;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       BTN_LEFT = 1'b0;
  logic       BTN_RIGHT = 1'b0;
  logic       ENABLE = 1'b0;
  logic       VSYNC = 1'b0;
  logic [9:0] PADDLE_X_PIXEL;
  logic       FRAME_TICK;
  logic       MOVING;

  int total = 0;
  int bad = 0;
  logic [10:0] sb_q[$];

  paddle_controller #(
    .DEBOUNCE_CYCLES(20'd4)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .BTN_LEFT(BTN_LEFT),
    .BTN_RIGHT(BTN_RIGHT),
    .ENABLE(ENABLE),
    .VSYNC(VSYNC),
    .PADDLE_X_PIXEL(PADDLE_X_PIXEL),
    .FRAME_TICK(FRAME_TICK),
    .MOVING(MOVING)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: the X update lands on the edge where FRAME_TICK is high
  always begin
    logic [10:0] e;
    @(negedge CLK);
    if (FRAME_TICK === 1'b1) begin
      @(negedge CLK);
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick: got x=%0d mv=%0b want none",
                 PADDLE_X_PIXEL, MOVING);
      end else begin
        e = sb_q.pop_front();
        if ({MOVING, PADDLE_X_PIXEL} !== e) begin
          bad++;
          $display("FAIL frame: got x=%0d mv=%0b want x=%0d mv=%0b",
                   PADDLE_X_PIXEL, MOVING, e[9:0], e[10]);
        end
      end
    end
  end

  task automatic frame(input int ex, input bit em);
    sb_q.push_back({em, ex[9:0]});
    VSYNC = 1'b1;
    repeat (3) @(negedge CLK);
    VSYNC = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic settle();
    repeat (10) @(negedge CLK);
  endtask

  int x;
  int spd;
  int n;
  int clamp_x[13] = '{21, 20, 19, 18, 16, 14, 12, 10, 8, 8, 8, 8, 8};

  initial begin
    // async reset between edges, no clock edge needed
    #3 RST_N = 1'b0;
    #1;
    chk("rst_x", PADDLE_X_PIXEL, 370);
    chk("rst_mv", MOVING, 0);
    chk("rst_tick", FRAME_TICK, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    ENABLE = 1'b1;
    repeat (4) @(negedge CLK);

    // tick latency: rises on third edge after the sampling edge
    sb_q.push_back({1'b0, 10'd370});
    VSYNC = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK);
      #1;
      if (FRAME_TICK === 1'b1 && n == 0) n = i;
    end
    chk("tick_latency", n, 4);
    @(negedge CLK);
    VSYNC = 1'b0;
    repeat (5) @(negedge CLK);

    // short pulse is rejected
    BTN_RIGHT = 1'b1;
    repeat (3) @(negedge CLK);
    BTN_RIGHT = 1'b0;
    settle();
    repeat (3) frame(370, 0);

    // held press is accepted, then accelerates
    BTN_RIGHT = 1'b1;
    settle();
    frame(371, 1); frame(372, 1); frame(373, 1);
    frame(374, 1); frame(376, 1); frame(378, 1);
    frame(380, 1); frame(382, 1); frame(385, 1);
    frame(388, 1); frame(391, 1); frame(394, 1);
    frame(398, 1);

    // reversal restarts at speed 1, both buttons idles
    BTN_RIGHT = 1'b0;
    BTN_LEFT = 1'b1;
    settle();
    frame(397, 1);
    BTN_RIGHT = 1'b1;
    settle();
    frame(397, 0);
    frame(397, 0);

    // enable low freezes and idles; debounce keeps running
    BTN_RIGHT = 1'b0;
    settle();
    frame(396, 1);
    frame(395, 1);
    ENABLE = 1'b0;
    frame(395, 0);
    frame(395, 0);
    BTN_LEFT = 1'b0;
    settle();
    ENABLE = 1'b1;
    frame(395, 0);

    // reset mid-move
    BTN_RIGHT = 1'b1;
    settle();
    frame(396, 1);
    frame(397, 1);
    BTN_RIGHT = 1'b0;
    @(negedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk("midrst_x", PADDLE_X_PIXEL, 370);
    chk("midrst_mv", MOVING, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    settle();

    // long left run down to X=22
    BTN_LEFT = 1'b1;
    settle();
    x = 370;
    for (int i = 0; i < 68; i++) begin
      spd = (i / 4 + 1 > 6) ? 6 : i / 4 + 1;
      x = x - spd;
      frame(x, 1);
    end
    chk("run_end", x, 22);
    BTN_RIGHT = 1'b1;
    settle();
    frame(22, 0);
    BTN_RIGHT = 1'b0;
    settle();

    // clamp at the left wall without leaving MOVE_LEFT
    for (int i = 0; i < 13; i++) frame(clamp_x[i], 1);
    chk("clamp_speed", dut.r_speed, 4);

    settle();
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paddle_controller.md
PADDLE_CONTROLLER -- requirements
Module: paddle_controller

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- PADDLE_LENGTH_PIXEL, 10'd60, paddle width in pixels.
- MIN_X_PIXEL, 10'd8, leftmost legal paddle X (first pixel right of the left wall).
- MAX_X_PIXEL, 10'd732, rightmost legal paddle X (792 - PADDLE_LENGTH_PIXEL).
- RESET_X_PIXEL, 10'd370, paddle X after reset (centred).
- DEBOUNCE_CYCLES, 20'd500000, number of consecutive stable CLK cycles needed to accept a button change.
- ACCEL_FRAMES, 4'd4, frame ticks per speed increment.
- MAX_SPEED, 4'd6, speed ceiling in pixels per frame.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, input, 1, pixel clock shared with the renderer.
- RST_N, input, 1, asynchronous active-low reset.
- BTN_LEFT, input, 1, raw asynchronous left button, active-high.
- BTN_RIGHT, input, 1, raw asynchronous right button, active-high.
- ENABLE, input, 1, game running; movement is permitted only while high.
- VSYNC, input, 1, vertical sync from the video interface; its rising edge marks a frame.
- PADDLE_X_PIXEL, output, 10, registered paddle left-edge X that feeds the renderer.
- FRAME_TICK, output, 1, registered one-cycle pulse per VSYNC rising edge.
- MOVING, output, 1, high while the FSM is in MOVE_LEFT or MOVE_RIGHT.

Function
REQ-003 BTN_LEFT, BTN_RIGHT and VSYNC SHALL each pass through a two-flop synchronizer before any use.
REQ-004 Each synchronized button SHALL have its own debouncer:
- A counter clears whenever the synchronized value equals the accepted value.
- Otherwise the counter increments.
- The accepted value updates on the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter clears on that cycle.
REQ-005 FRAME_TICK SHALL be high for exactly one cycle, detected as synchronized VSYNC high while its delayed copy is low.
REQ-006 FRAME_TICK SHALL rise at the third CLK edge after the edge that first samples VSYNC high.
REQ-007 Direction request SHALL be taken from the accepted button values:
- Left accepted and right not accepted: LEFT.
- Right accepted and left not accepted: RIGHT.
- Both accepted or neither accepted: NONE.
REQ-008 The FSM SHALL have three states, IDLE, MOVE_LEFT and MOVE_RIGHT, and SHALL evaluate transitions only on cycles where FRAME_TICK is high.
REQ-009 FSM transitions on a FRAME_TICK cycle SHALL be:
- ENABLE low: go to IDLE.
- Otherwise, request NONE: go to IDLE.
- Otherwise, request LEFT: go to MOVE_LEFT.
- Otherwise, request RIGHT: go to MOVE_RIGHT.
REQ-010 A 4-bit speed register SHALL load 1 on any transition into MOVE_LEFT or MOVE_RIGHT, including a direct reversal, and SHALL reset the frame counter at the same time.
REQ-011 While the FSM stays in the same MOVE state, speed and the frame counter SHALL update on each FRAME_TICK:
- The frame counter increments.
- When it reaches ACCEL_FRAMES-1, speed increments (saturating at MAX_SPEED) and the frame counter clears.
REQ-012 On a FRAME_TICK cycle whose next state is MOVE_LEFT or MOVE_RIGHT, PADDLE_X_PIXEL SHALL move by the speed value that takes effect on that same edge: subtract for left, add for right.
REQ-013 The position arithmetic SHALL be done at 11 bits, and the result SHALL be clamped to [MIN_X_PIXEL, MAX_X_PIXEL] with no wrap-around.
REQ-014 Reaching a clamp limit SHALL NOT change FSM state or speed.
REQ-015 PADDLE_X_PIXEL SHALL change only on the edge where FRAME_TICK is high, one edge after FRAME_TICK rises, and SHALL be constant for the rest of the frame.
REQ-016 When ENABLE is low, PADDLE_X_PIXEL SHALL hold its value; debouncing SHALL continue to run.
REQ-017 MOVING SHALL be a registered decode of the current FSM state.

Reset
REQ-018 While RST_N is low, the block SHALL immediately force these values regardless of CLK:
- PADDLE_X_PIXEL = RESET_X_PIXEL.
- FRAME_TICK = 0.
- MOVING = 0.
- FSM = IDLE.
- speed = 0.
- All counters = 0.
- Synchronizers and accepted button values = 0.
REQ-019 A reset asserted mid-frame or mid-move SHALL discard any pending update, and the first FRAME_TICK after release SHALL follow REQ-006.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-020 Reset: drive RST_N=0 between clock edges -> PADDLE_X_PIXEL=370, MOVING=0 without waiting for an edge.
REQ-021 Debounce: pulse BTN_RIGHT high for 3 cycles -> no acceptance, and PADDLE_X_PIXEL stays 370 over 3 frames; hold it for 6+ cycles -> accepted; next tick -> 371.
REQ-022 Acceleration: hold right with ENABLE=1 over 9 ticks -> X after each tick: 371, 372, 373, 374, 376, 378, 380, 382, 385.
REQ-023 Clamp: start at X=10, hold left at speed 3 -> next tick gives 8 (not 7, not wrap to 1023), MOVING stays 1, and speed keeps incrementing.
REQ-024 Reversal and simultaneous press: reverse from right at speed 4 to left -> speed 1 and X decreases by 1; press both buttons -> IDLE and X frozen.
REQ-025 ENABLE and reset mid-move: drop ENABLE while moving -> X frozen and IDLE at next tick; pulse RST_N low between ticks -> X=370 immediately.
